// File: rtl/mpei_tcm_boot_loader.sv
// rtl/mpei_tcm_boot_loader.sv - framed byte-stream TCM preloader with checksum and core reset sequencing
module mpei_tcm_boot_loader #(
    parameter  int DATA_W    = 32,
    parameter  int DEPTH     = 1024,
    parameter  int BASE_ADDR = 0,
    parameter  int HOLD_CYC  = 15,
    localparam int NB        = DATA_W / 8,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              bypass_i,
    input  logic              s_valid_i,
    input  logic [7:0]        s_data_i,
    output logic              s_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              core_rstn_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic [15:0]       words_o
);

    localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(BASE_ADDR % DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_HOLD, S_RUN, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W-1:0] addr_ptr_q, addr_ptr_d;
    logic [31:0]       hold_cnt_q, hold_cnt_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [15:0]       words_q, words_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              s_ready_q, s_ready_d;
    logic              busy_q, busy_d;
    logic              core_rstn_q, core_rstn_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic [15:0]       len_full;

    // Next-state and datapath: frame parsing, word assembly, checksum and hold timing
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        csum_d      = csum_q;
        addr_ptr_d  = addr_ptr_q;
        hold_cnt_d  = hold_cnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        words_d     = words_q;
        err_code_d  = err_code_q;
        accept      = s_valid_i && s_ready_q;
        len_full    = {s_data_i, len_q[7:0]};

        case (state_q)
            S_IDLE: begin
                hold_cnt_d = '0;
                state_d    = bypass_i ? S_HOLD : S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = s_data_i;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    if (len_full == 16'd0) begin
                        err_code_d = 2'd1;
                        state_d    = S_ERR;
                    end else if ({16'd0, len_full} > 32'(DEPTH)) begin
                        err_code_d = 2'd2;
                        state_d    = S_ERR;
                    end else begin
                        len_d      = len_full;
                        byte_cnt_d = '0;
                        csum_d     = 8'd0;
                        words_d    = 16'd0;
                        addr_ptr_d = START_ADDR;
                        state_d    = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_d[int'(byte_cnt_q)*8 +: 8] = s_data_i;
                    csum_d = csum_q ^ s_data_i;
                    if (byte_cnt_q == BC_W'(NB - 1)) begin
                        // Word complete: the write issues next cycle while the next word streams in
                        byte_cnt_d  = '0;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = addr_ptr_q;
                        mem_wdata_d = word_d;
                        words_d     = words_q + 16'd1;
                        addr_ptr_d  = (addr_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_ptr_q + 1'b1;
                        if (words_q == len_q - 16'd1) begin
                            state_d = S_CSUM;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (s_data_i == csum_q) begin
                        hold_cnt_d = '0;
                        state_d    = S_HOLD;
                    end else begin
                        err_code_d = 2'd3;
                        state_d    = S_ERR;
                    end
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == 32'(HOLD_CYC - 1)) begin
                    state_d = S_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 32'd1;
                end
            end
            S_RUN:   state_d = S_RUN;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase

        s_ready_d   = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                      (state_d == S_DATA)   || (state_d == S_CSUM);
        busy_d      = s_ready_d;
        core_rstn_d = (state_d == S_RUN);
        done_d      = (state_d == S_RUN);
        err_d       = (state_d == S_ERR);
    end

    // State and registered outputs, all cleared asynchronously
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            csum_q      <= '0;
            addr_ptr_q  <= '0;
            hold_cnt_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            words_q     <= '0;
            err_code_q  <= '0;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            core_rstn_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            csum_q      <= csum_d;
            addr_ptr_q  <= addr_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            words_q     <= words_d;
            err_code_q  <= err_code_d;
            s_ready_q   <= s_ready_d;
            busy_q      <= busy_d;
            core_rstn_q <= core_rstn_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign s_ready_o   = s_ready_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign core_rstn_o = core_rstn_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;
    assign words_o     = words_q;

endmodule

// File: tb/tb_mpei_tcm_boot_loader.sv
// tb/tb_mpei_tcm_boot_loader.sv - randomized self-checking bench for mpei_tcm_boot_loader
module tb_mpei_tcm_boot_loader;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 1024;
    localparam int BASE_ADDR = 0;
    localparam int HOLD_CYC  = 15;
    localparam int NB        = DATA_W / 8;
    localparam int ADDR_W    = $clog2(DEPTH);

    logic              clk_i = 1'b0;
    logic              rstn_i = 1'b0;
    logic              bypass_i = 1'b0;
    logic              s_valid_i = 1'b0;
    logic [7:0]        s_data_i = 8'd0;
    logic              s_ready_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              core_rstn_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [1:0]        err_code_o;
    logic [15:0]       words_o;

    mpei_tcm_boot_loader #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR), .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .bypass_i(bypass_i),
        .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .core_rstn_o(core_rstn_o), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .err_code_o(err_code_o), .words_o(words_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]        frame_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [DATA_W-1:0] exp_data_q[$];
    logic [DATA_W-1:0] got_mem[4];
    int                wr_seen = 0;
    int                rise_cyc = -1;
    int                first_edge = 0;
    int                acc_cyc = 0;
    int                exp_code = 0;
    int                exp_words = 0;
    logic [7:0]        exp_csum = 8'd0;
    logic              prev_cr = 1'b0;
    bit                ready_seen = 1'b0;

    logic [7:0] s2_bytes[11] = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                                 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Per-cycle checker: writes against the model queue, plus status relations that hold at all times
    always @(negedge clk_i) begin
        if (rstn_i) begin
            if (s_ready_o) ready_seen = 1'b1;
            if (mem_we_o) begin
                if (exp_addr_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr_o, mem_wdata_o);
                end else begin
                    chk("wr_addr", 64'(mem_addr_o), 64'(exp_addr_q.pop_front()));
                    chk("wr_data", 64'(mem_wdata_o), 64'(exp_data_q.pop_front()));
                end
                if (mem_addr_o < 4) got_mem[mem_addr_o[1:0]] = mem_wdata_o;
                wr_seen++;
            end
            chk("words_track", 64'(words_o), 64'(wr_seen));
            chk("busy_eq_ready", 64'(busy_o), 64'(s_ready_o));
            chk("core_rstn_eq_done", 64'(core_rstn_o), 64'(done_o));
            chk("err_eq_code_nz", 64'(err_o), 64'(err_code_o != 2'd0));
            if (done_o || err_o) chk("ready_after_end", 64'(s_ready_o), 64'd0);
            if (core_rstn_o && !prev_cr) rise_cyc = cyc;
        end
        prev_cr = core_rstn_o;
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"},   64'(s_ready_o),   64'd0);
        chk({tag, "_mem_we"},    64'(mem_we_o),    64'd0);
        chk({tag, "_mem_addr"},  64'(mem_addr_o),  64'd0);
        chk({tag, "_mem_wdata"}, 64'(mem_wdata_o), 64'd0);
        chk({tag, "_core_rstn"}, 64'(core_rstn_o), 64'd0);
        chk({tag, "_busy"},      64'(busy_o),      64'd0);
        chk({tag, "_done"},      64'(done_o),      64'd0);
        chk({tag, "_err"},       64'(err_o),       64'd0);
        chk({tag, "_err_code"},  64'(err_code_o),  64'd0);
        chk({tag, "_words"},     64'(words_o),     64'd0);
    endtask

    task automatic do_reset(input bit byp);
        @(negedge clk_i);
        rstn_i = 1'b0;
        bypass_i = byp;
        s_valid_i = 1'b0;
        s_data_i = 8'd0;
        exp_addr_q.delete();
        exp_data_q.delete();
        wr_seen = 0;
        rise_cyc = -1;
        ready_seen = 1'b0;
        for (int i = 0; i < 4; i++) got_mem[i] = '0;
        @(negedge clk_i);
        check_reset_outputs("reset");
        @(negedge clk_i);
        rstn_i = 1'b1;
        first_edge = cyc + 1;
    endtask

    // Reference: what a frame must produce, straight from the frame format rules
    task automatic model_frame();
        int n;
        logic [7:0] x;
        logic [DATA_W-1:0] d;
        n = int'(frame_q[0]) | (int'(frame_q[1]) << 8);
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_words = 0;
        x = 8'd0;
        if (n == 0) exp_code = 1;
        else if (n > DEPTH) exp_code = 2;
        else begin
            for (int w = 0; w < n; w++) begin
                d = '0;
                for (int k = 0; k < NB; k++) begin
                    d = d | (DATA_W'(frame_q[2 + w*NB + k]) << (8*k));
                    x = x ^ frame_q[2 + w*NB + k];
                end
                exp_addr_q.push_back(ADDR_W'((BASE_ADDR + w) % DEPTH));
                exp_data_q.push_back(d);
            end
            exp_words = n;
            exp_code = (frame_q[2 + n*NB] == x) ? 0 : 3;
        end
        exp_csum = x;
    endtask

    task automatic send_frame(input int gmax);
        int g;
        int k;
        for (int i = 0; i < frame_q.size(); i++) begin
            g = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
            repeat (g) begin
                @(negedge clk_i);
                s_valid_i = 1'b0;
            end
            @(negedge clk_i);
            s_valid_i = 1'b1;
            s_data_i = frame_q[i];
            k = 0;
            while (!s_ready_o && k < 300) begin
                @(negedge clk_i);
                k++;
            end
            if (!s_ready_o) begin
                n_cmp++;
                n_err++;
                $display("FAIL byte_stall: got no s_ready_o for byte %0d expected accept within 300 cycles", i);
                break;
            end
            acc_cyc = cyc + 1;
        end
        @(negedge clk_i);
        s_valid_i = 1'b0;
    endtask

    task automatic wait_end();
        int k = 0;
        while (!(done_o || err_o) && k < 200) begin
            @(negedge clk_i);
            k++;
        end
        if (!(done_o || err_o)) begin
            n_cmp++;
            n_err++;
            $display("FAIL end_timeout: got done=%0b err=%0b expected completion within 200 cycles", done_o, err_o);
        end
        repeat (3) @(negedge clk_i);
    endtask

    task automatic run_frame(input int gmax);
        model_frame();
        send_frame(gmax);
        wait_end();
        chk("err_code", 64'(err_code_o), 64'(exp_code));
        chk("done", 64'(done_o), 64'(exp_code == 0));
        chk("err", 64'(err_o), 64'(exp_code != 0));
        chk("words_final", 64'(words_o), 64'(exp_words));
        chk("writes_left", 64'(exp_addr_q.size()), 64'd0);
        if (exp_code == 0) chk("rise_time", 64'(rise_cyc), 64'(acc_cyc + HOLD_CYC));
        else               chk("no_rise", 64'(rise_cyc), 64'(-1));
    endtask

    task automatic load_s2(input logic [7:0] cs);
        frame_q.delete();
        for (int i = 0; i < 10; i++) frame_q.push_back(s2_bytes[i]);
        frame_q.push_back(cs);
    endtask

    initial begin
        logic [7:0] x;
        logic [7:0] b;
        int n;

        // Bypass
        do_reset(1'b1);
        wait_end();
        chk("bypass_rise", 64'(rise_cyc), 64'(first_edge + HOLD_CYC));
        chk("bypass_done", 64'(done_o), 64'd1);
        chk("bypass_no_ready", 64'(ready_seen), 64'd0);
        chk("bypass_no_write", 64'(wr_seen), 64'd0);

        // Nominal frame, back-to-back
        do_reset(1'b0);
        load_s2(8'h2A);
        run_frame(0);
        chk("s2_model_csum", 64'(exp_csum), 64'h2A);
        chk("s2_mem0", 64'(got_mem[0]), 64'h12345678);
        chk("s2_mem1", 64'(got_mem[1]), 64'hDEADBEEF);
        chk("s2_words", 64'(words_o), 64'd2);

        // Bad checksum
        do_reset(1'b0);
        load_s2(8'h2B);
        run_frame(0);
        chk("s3_code", 64'(err_code_o), 64'd3);
        chk("s3_mem1", 64'(got_mem[1]), 64'hDEADBEEF);
        repeat (5) @(negedge clk_i);
        chk("s3_ready_low", 64'(s_ready_o), 64'd0);

        // Zero length and over-length
        do_reset(1'b0);
        frame_q = '{8'h00, 8'h00};
        run_frame(0);
        chk("s4_zero_code", 64'(err_code_o), 64'd1);
        chk("s4_zero_nowr", 64'(wr_seen), 64'd0);
        do_reset(1'b0);
        frame_q = '{8'h01, 8'h04};
        run_frame(0);
        chk("s4_big_code", 64'(err_code_o), 64'd2);
        chk("s4_big_nowr", 64'(wr_seen), 64'd0);

        // Nominal frame with random gaps
        do_reset(1'b0);
        load_s2(8'h2A);
        run_frame(5);
        chk("s5_mem0", 64'(got_mem[0]), 64'h12345678);
        chk("s5_mem1", 64'(got_mem[1]), 64'hDEADBEEF);

        // Reset in the middle of a word, then a clean reload
        do_reset(1'b0);
        frame_q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34};
        send_frame(0);
        @(posedge clk_i);
        #2;
        rstn_i = 1'b0;
        wr_seen = 0;
        #1;
        check_reset_outputs("midreset");
        do_reset(1'b0);
        load_s2(8'h2A);
        run_frame(0);
        chk("s6_mem0", 64'(got_mem[0]), 64'h12345678);

        // Random frames, some with corrupted checksum
        for (int r = 0; r < 8; r++) begin
            do_reset(1'b0);
            n = int'($urandom_range(1, 6));
            frame_q.delete();
            frame_q.push_back(8'(n));
            frame_q.push_back(8'h00);
            x = 8'd0;
            for (int i = 0; i < n*NB; i++) begin
                b = 8'($urandom);
                x = x ^ b;
                frame_q.push_back(b);
            end
            if ($urandom_range(0, 2) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
            frame_q.push_back(x);
            run_frame(3);
        end

        // Largest legal frame, back-to-back
        do_reset(1'b0);
        frame_q.delete();
        frame_q.push_back(8'(DEPTH & 8'hFF));
        frame_q.push_back(8'(DEPTH >> 8));
        x = 8'd0;
        for (int i = 0; i < DEPTH*NB; i++) begin
            b = 8'($urandom);
            x = x ^ b;
            frame_q.push_back(b);
        end
        frame_q.push_back(x);
        run_frame(0);
        chk("full_words", 64'(words_o), 64'(DEPTH));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
